// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the mmio_console register window.
//   OFF_*      word offsets (Adr - BASE)[3:2] of the four registers
//   CTRL_*     bit indices of the CTRL write strobes
//   ST_*       bit positions inside the STATUS word
//   status_word() packs the STATUS register from its fields.
package mmio_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_CYCLES = 2'd3;

  localparam int CTRL_CLR_OVF = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_DONE    = 2;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 8;

  function automatic logic [31:0] status_word(input logic empty, input logic full,
                                              input logic ovf, input logic [7:0] cnt);
    logic [31:0] w;
    w                   = 32'd0;
    w[ST_EMPTY]         = empty;
    w[ST_FULL]          = full;
    w[ST_OVF]           = ovf;
    w[ST_CNT_LSB +: 8]  = cnt;
    return w;
  endfunction

endpackage

// File: rtl/mmio_fifo.sv
// mmio_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst_n       clock, asynchronous active-low reset (pointers/count only)
//   push, wdata      enqueue request; ignored when full unless a pop happens too
//   pop              dequeue request; ignored when empty
//   flush            empties the FIFO; overrides push and pop
//   head             current head word, 0 while empty
//   empty, full      occupancy flags
//   count            number of stored entries (0..DEPTH)
module mmio_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic           do_push_s, do_pop_s;

  // Occupancy flags, accepted push/pop and next pointer/count state.
  always_comb begin
    empty     = (count_q == {(AW+1){1'b0}});
    full      = (count_q == CNT_FULL);
    do_pop_s  = pop & ~empty;
    // A push into a full FIFO is only accepted when a pop frees a slot at the same edge.
    do_push_s = push & (~full | do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Head word; forced to zero while empty so stale storage never leaks out.
  always_comb begin
    if (empty) begin
      head = {WIDTH{1'b0}};
    end else begin
      head = mem_q[rd_ptr_q];
    end
  end

  assign count = count_q;

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; deliberately not reset, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/mmio_console.sv
// mmio_console: memory-mapped console responder on the CPU data bus.
// Optional feature macro: MMIO_CONSOLE_CYCLES_EN (free-running cycle counter at +12).
//   clk, reset            clock, asynchronous active-low reset
//   Adr, WriteData        CPU byte address and store data
//   MemWrite              CPU store strobe
//   hit                   Adr lies in [BASE, BASE+15] (combinational)
//   rdata                 read data of the addressed register (combinational)
//   out_valid, out_data   FIFO head towards the sink (first-word-fall-through)
//   out_ready             sink accepts the head at a clock edge
//   done                  sticky flag set by a CTRL store with bit 2
module mmio_console
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE  = 32'd100,
  parameter int          DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        done
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   off_s;
  logic [1:0]    reg_sel_s;
  logic          wr_s, push_s, pop_s, ctrl_wr_s, flush_s;
  logic          fifo_empty_s, fifo_full_s;
  logic [CW-1:0] fifo_count_s;
  logic [31:0]   cycles_s;
  logic          overflow_q, overflow_d;
  logic          done_q, done_d;
  logic          adr_lsb_unused_s;

  // BASE is only word-aligned, so the window is decoded from the difference
  // to BASE; an address below BASE wraps to a large value and misses.
  always_comb begin
    off_s     = Adr - BASE;
    hit       = (off_s[31:4] == 28'd0);
    reg_sel_s = off_s[3:2];
    wr_s      = MemWrite & hit;
    push_s    = wr_s & (reg_sel_s == OFF_DATA);
    ctrl_wr_s = wr_s & (reg_sel_s == OFF_CTRL);
    flush_s   = ctrl_wr_s & WriteData[CTRL_FLUSH];
    pop_s     = out_valid & out_ready;
  end

  // Byte lane bits play no part in decode.
  assign adr_lsb_unused_s = ^off_s[1:0];

  mmio_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push_s),
    .pop   (pop_s),
    .flush (flush_s),
    .wdata (WriteData),
    .head  (out_data),
    .empty (fifo_empty_s),
    .full  (fifo_full_s),
    .count (fifo_count_s)
  );

  assign out_valid = ~fifo_empty_s;

  // Sticky overflow/done next state; clearing overflow has priority.
  always_comb begin
    overflow_d = overflow_q;
    done_d     = done_q | (ctrl_wr_s & WriteData[CTRL_DONE]);
    if (ctrl_wr_s && WriteData[CTRL_CLR_OVF]) begin
      overflow_d = 1'b0;
    end else if (push_s && fifo_full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Sticky status flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign done = done_q;

`ifdef MMIO_CONSOLE_CYCLES_EN
  logic [31:0] cycles_q, cycles_d;

  // Free-running counter; a store to +12 preloads it.
  always_comb begin
    if (wr_s && (reg_sel_s == OFF_CYCLES)) begin
      cycles_d = WriteData;
    end else begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles_q <= 32'd0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign cycles_s = cycles_q;
`else
  assign cycles_s = 32'd0;
`endif

  // Read mux; reads have no side effects and return 0 outside the window.
  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (reg_sel_s)
        OFF_DATA:   rdata = out_data;
        OFF_STATUS: rdata = status_word(fifo_empty_s, fifo_full_s, overflow_q, 8'(fifo_count_s));
        OFF_CTRL:   rdata = {29'd0, done_q, 2'd0};
        OFF_CYCLES: rdata = cycles_s;
        default:    rdata = 32'd0;
      endcase
    end else begin
      rdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_mmio_console.sv
// tb_mmio_console: table-driven bench for mmio_console with a scoreboard of
// expected drained words (pushed when a store is predicted to be accepted,
// popped when the sink handshake happens).
module tb_mmio_console;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Adr, WriteData;
  logic        MemWrite, out_ready;
  logic        hit, out_valid, done;
  logic [31:0] rdata, out_data;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb[$];
  int          mcnt = 0;

`ifdef MMIO_CONSOLE_CYCLES_EN
  localparam bit CYC = 1'b1;
`else
  localparam bit CYC = 1'b0;
`endif

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wd;
    bit          we;
    bit          rdy;
    logic [31:0] chk_adr;
    logic [31:0] exp_rd;
    bit          exp_v;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  mmio_console #(.BASE(32'd100), .DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .Adr       (Adr),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .hit       (hit),
    .rdata     (rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .done      (done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] st(input int c, input bit ovf);
    logic [7:0] c8;
    c8 = c[7:0];
    return {16'h0, c8, 5'h0, ovf, (c == 8) ? 1'b1 : 1'b0, (c == 0) ? 1'b1 : 1'b0};
  endfunction

  task automatic add(input logic [31:0] a, input logic [31:0] wd, input bit we, input bit rdy,
                     input logic [31:0] ca, input logic [31:0] er, input bit ev);
    vec_t v;
    v.adr = a; v.wd = wd; v.we = we; v.rdy = rdy;
    v.chk_adr = ca; v.exp_rd = er; v.exp_v = ev;
    vecs.push_back(v);
  endtask

  // One bus cycle: drive, predict, clock, then read back chk_a after the edge.
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input bit we, input bit rdy,
                      input logic [31:0] ca, input logic [31:0] er, input bit ev);
    logic [31:0] d;
    bit pop_m, acc, fl;
    Adr = a; WriteData = wd; MemWrite = we; out_ready = rdy;
    d     = a - 32'd100;
    pop_m = (mcnt > 0) && rdy;
    acc   = we && (d < 32'd16) && (d[3:2] == 2'd0) && ((mcnt < 8) || pop_m);
    fl    = we && (d < 32'd16) && (d[3:2] == 2'd2) && wd[1];
    if (acc) sb.push_back(wd);
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    if (fl) begin
      mcnt = 0;
      sb.delete();
    end else begin
      mcnt = mcnt + (acc ? 1 : 0) - (pop_m ? 1 : 0);
    end
    Adr = ca;
    #1;
    chk("rdata", rdata, er);
    chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
    if (ev && sb.size() > 0) chk("out_data head", out_data, sb[0]);
    else if (!ev) chk("out_data empty", out_data, 32'd0);
  endtask

  // Sink monitor: every accepted head must be the oldest expected word.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL drain: unexpected word %h expected none", out_data);
      end else begin
        chk("drain order", out_data, sb.pop_front());
      end
    end
  end

  initial begin
    // Vector table.
    add(32'd100, 32'd7, 1'b1, 1'b0, 32'd104, st(1, 1'b0), 1'b1);
    add(32'd100, 32'd0, 1'b0, 1'b0, 32'd100, 32'd7, 1'b1);
    add(32'd0,   32'd0, 1'b0, 1'b1, 32'd104, st(0, 1'b0), 1'b0);
    for (int i = 1; i <= 8; i++) add(32'd100, 32'(i), 1'b1, 1'b0, 32'd104, st(i, 1'b0), 1'b1);
    add(32'd100, 32'd9, 1'b1, 1'b0, 32'd104, st(8, 1'b1), 1'b1);
    for (int k = 1; k <= 8; k++) add(32'd0, 32'd0, 1'b0, 1'b1, 32'd104, st(8 - k, 1'b1), (8 - k) > 0);
    add(32'd108, 32'd1, 1'b1, 1'b0, 32'd104, st(0, 1'b0), 1'b0);
    for (int i = 0; i < 8; i++) add(32'd100, 32'h10 + 32'(i), 1'b1, 1'b0, 32'd104, st(i + 1, 1'b0), 1'b1);
    add(32'd100, 32'hAA, 1'b1, 1'b1, 32'd104, st(8, 1'b0), 1'b1);
    for (int k = 0; k < 8; k++) add(32'd0, 32'd0, 1'b0, 1'b1, 32'd104, st(7 - k, 1'b0), (7 - k) > 0);
    for (int i = 1; i <= 3; i++) add(32'd100, 32'h20 + 32'(i), 1'b1, 1'b0, 32'd104, st(i, 1'b0), 1'b1);
    add(32'd108, 32'd2, 1'b1, 1'b1, 32'd104, st(0, 1'b0), 1'b0);
    add(32'd0,   32'd0, 1'b0, 1'b1, 32'd104, st(0, 1'b0), 1'b0);
    add(32'd116, 32'd5, 1'b1, 1'b1, 32'd104, st(0, 1'b0), 1'b0);
    add(32'd96,  32'd5, 1'b1, 1'b1, 32'd104, st(0, 1'b0), 1'b0);
    add(32'd103, 32'h55, 1'b1, 1'b0, 32'd101, 32'h55, 1'b1);
    add(32'd0,   32'd0, 1'b0, 1'b1, 32'd104, st(0, 1'b0), 1'b0);

    // Reset state, checked asynchronously before any edge.
    reset = 1'b0; Adr = 32'd104; WriteData = 32'd0; MemWrite = 1'b0; out_ready = 1'b0;
    #3;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out_data", out_data, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset status", rdata, st(0, 1'b0));
    Adr = 32'd112; #1; chk("reset cycles", rdata, 32'd0);
    Adr = 32'd99;  #1; chk("hit below", {31'd0, hit}, 32'd0);
    Adr = 32'd100; #1; chk("hit base", {31'd0, hit}, 32'd1);
    Adr = 32'd115; #1; chk("hit top", {31'd0, hit}, 32'd1);
    Adr = 32'd116; #1; chk("hit above", {31'd0, hit}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;

    foreach (vecs[i]) step(vecs[i].adr, vecs[i].wd, vecs[i].we, vecs[i].rdy,
                           vecs[i].chk_adr, vecs[i].exp_rd, vecs[i].exp_v);

    // done is set one edge after the CTRL store.
    Adr = 32'd108; WriteData = 32'd4; MemWrite = 1'b1;
    #1;
    chk("done before edge", {31'd0, done}, 32'd0);
    step(32'd108, 32'd4, 1'b1, 1'b0, 32'd108, 32'd4, 1'b0);
    chk("done set", {31'd0, done}, 32'd1);

    // Asynchronous reset in the middle of a drain.
    step(32'd100, 32'h31, 1'b1, 1'b0, 32'd104, st(1, 1'b0), 1'b1);
    step(32'd100, 32'h32, 1'b1, 1'b0, 32'd104, st(2, 1'b0), 1'b1);
    step(32'd0,   32'd0,  1'b0, 1'b1, 32'd104, st(1, 1'b0), 1'b1);
    #1;
    reset = 1'b0;
    Adr = 32'd104;
    #1;
    chk("async reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("async reset done", {31'd0, done}, 32'd0);
    chk("async reset status", rdata, st(0, 1'b0));
    chk("async reset out_data", out_data, 32'd0);
    mcnt = 0;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    step(32'd0, 32'd0, 1'b0, 1'b1, 32'd104, st(0, 1'b0), 1'b0);

    // Cycle counter preload and wrap (reads 0 when compiled out).
    step(32'd112, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'd112, CYC ? 32'hFFFF_FFFE : 32'd0, 1'b0);
    step(32'd0, 32'd0, 1'b0, 1'b0, 32'd112, CYC ? 32'hFFFF_FFFF : 32'd0, 1'b0);
    step(32'd0, 32'd0, 1'b0, 1'b0, 32'd112, 32'd0, 1'b0);
    step(32'd0, 32'd0, 1'b0, 1'b0, 32'd104, st(0, 1'b0), 1'b0);

    chk("scoreboard leftover", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
